// File: rtl/axi_load_port_pkg.sv
// Shared constants for the AXI load port: owner encoding, AXI burst/response codes
// and the FSM state type.
package axi_load_port_pkg;

    localparam logic [1:0] OWN_M0 = 2'b00;
    localparam logic [1:0] OWN_M1 = 2'b01;
    localparam logic [1:0] OWN_M2 = 2'b10;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAddr = 2'b01,
        StData = 2'b10,
        StDone = 2'b11
    } state_e;

    // One-hot master select for an owner code; unused code maps to no master.
    function automatic logic [2:0] own_onehot(input logic [1:0] own);
        logic [2:0] oh;
        oh = 3'b000;
        case (own)
            OWN_M0:  oh = 3'b001;
            OWN_M1:  oh = 3'b010;
            OWN_M2:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/axi_load_port_if.sv
// AXI read-address and read-data channel bundle for the load port.
interface axi_load_port_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) ();

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_load_port.sv
// Bus-side end of the load bus: issues the granted master's read burst on AR and
// routes R beats back to the owning master until the burst's rlast.
module axi_load_port
    import axi_load_port_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m2_req,
    input  logic              m0_grnt,
    input  logic              m1_grnt,
    input  logic              m2_grnt,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [3:0]        m0_len,
    input  logic [3:0]        m1_len,
    input  logic [3:0]        m2_len,
    input  logic [2:0]        m0_size,
    input  logic [2:0]        m1_size,
    input  logic [2:0]        m2_size,

    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] m2_rdata,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic              m2_rvalid,
    output logic              m0_rlast,
    output logic              m1_rlast,
    output logic              m2_rlast,
    output logic              m0_done,
    output logic              m1_done,
    output logic              m2_done,
    output logic              m0_err,
    output logic              m1_err,
    output logic              m2_err,

    axi_load_port_if.master   axi
);

    state_e state_q, state_d;

    logic [1:0]        owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic              err_q;
    logic [2:0]        rvalid_q;
    logic [2:0]        rlast_q;
    logic [2:0][DATA_W-1:0] rdata_q;

    logic [2:0]        hit;
    logic [1:0]        sel_own;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_len;
    logic [2:0]        sel_size;
    logic              capture;
    logic              beat_ok;
    logic [ID_W-1:0]   cur_id;
    logic [2:0]        own_oh;
    logic [2:0]        done_oh;

    assign hit    = {m2_req & m2_grnt, m1_req & m1_grnt, m0_req & m0_grnt};
    assign cur_id = ID_W'(owner_q);
    assign own_oh = own_onehot(owner_q);

    // Fixed priority m0 > m1 > m2 in case the arbiter's grant is not one-hot.
    always_comb begin
        sel_own  = OWN_M0;
        sel_addr = m0_addr;
        sel_len  = m0_len;
        sel_size = m0_size;
        if (!hit[0] && hit[1]) begin
            sel_own  = OWN_M1;
            sel_addr = m1_addr;
            sel_len  = m1_len;
            sel_size = m1_size;
        end else if (!hit[0] && !hit[1] && hit[2]) begin
            sel_own  = OWN_M2;
            sel_addr = m2_addr;
            sel_len  = m2_len;
            sel_size = m2_size;
        end
    end

    // Beats with a foreign ID are still accepted (rready high) but never routed.
    assign beat_ok = axi.rvalid && (state_q == StData) && (axi.rid == cur_id);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|hit) begin
                    state_d = StAddr;
                    capture = 1'b1;
                end
            end
            StAddr: begin
                if (axi.arready) state_d = StData;
            end
            StData: begin
                if (beat_ok && axi.rlast) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_M0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            err_q    <= 1'b0;
            rvalid_q <= '0;
            rlast_q  <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            rlast_q  <= '0;
            if (capture) begin
                owner_q <= sel_own;
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                size_q  <= sel_size;
                err_q   <= 1'b0;
            end
            if (beat_ok) begin
                err_q <= err_q | (axi.rresp != RESP_OKAY);
                for (int i = 0; i < 3; i++) begin
                    if (own_oh[i]) begin
                        rdata_q[i]  <= axi.rdata;
                        rvalid_q[i] <= 1'b1;
                        rlast_q[i]  <= axi.rlast;
                    end
                end
            end
        end
    end

    assign done_oh = (state_q == StDone) ? own_oh : 3'b000;

    assign axi.arid    = cur_id;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = size_q;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (state_q == StAddr);
    assign axi.rready  = (state_q == StData);

    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m2_rdata  = rdata_q[2];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m2_rvalid = rvalid_q[2];
    assign m0_rlast  = rlast_q[0];
    assign m1_rlast  = rlast_q[1];
    assign m2_rlast  = rlast_q[2];
    assign m0_done   = done_oh[0];
    assign m1_done   = done_oh[1];
    assign m2_done   = done_oh[2];
    assign m0_err    = done_oh[0] & err_q;
    assign m1_err    = done_oh[1] & err_q;
    assign m2_err    = done_oh[2] & err_q;

endmodule

// File: tb/tb_axi_load_port.sv
// Directed bench for axi_load_port: hand-computed bursts, ID filtering, errors and reset.
module tb_axi_load_port;

    logic clk = 1'b0;
    logic rst_n;
    logic m0_req, m1_req, m2_req, m0_grnt, m1_grnt, m2_grnt;
    logic [31:0] m0_addr, m1_addr, m2_addr;
    logic [3:0]  m0_len, m1_len, m2_len;
    logic [2:0]  m0_size, m1_size, m2_size;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;
    logic m0_rvalid, m1_rvalid, m2_rvalid, m0_rlast, m1_rlast, m2_rlast;
    logic m0_done, m1_done, m2_done, m0_err, m1_err, m2_err;

    int checks = 0;
    int errors = 0;

    axi_load_port_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

    axi_load_port #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m2_req(m2_req),
        .m0_grnt(m0_grnt), .m1_grnt(m1_grnt), .m2_grnt(m2_grnt),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m2_addr(m2_addr),
        .m0_len(m0_len), .m1_len(m1_len), .m2_len(m2_len),
        .m0_size(m0_size), .m1_size(m1_size), .m2_size(m2_size),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m2_rdata(m2_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m2_rvalid(m2_rvalid),
        .m0_rlast(m0_rlast), .m1_rlast(m1_rlast), .m2_rlast(m2_rlast),
        .m0_done(m0_done), .m1_done(m1_done), .m2_done(m2_done),
        .m0_err(m0_err), .m1_err(m1_err), .m2_err(m2_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one R beat for exactly one cycle.
    task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
        axi.rvalid = 1'b1;
        axi.rid    = id;
        axi.rdata  = data;
        axi.rresp  = resp;
        axi.rlast  = last;
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {m0_req, m1_req, m2_req, m0_grnt, m1_grnt, m2_grnt} = '0;
        m0_addr = '0; m1_addr = '0; m2_addr = '0;
        m0_len = '0; m1_len = '0; m2_len = '0;
        m0_size = '0; m1_size = '0; m2_size = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0;
        axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        #1;
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_arburst", axi.arburst, 2'b01);
        chk("rst_outs", {m0_rvalid, m1_rvalid, m2_rvalid, m0_done, m1_done, m2_done,
                         m0_err, m1_err, m2_err}, 0);
        chk("rst_rdata", m0_rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // m0 burst, 4 beats, immediate arready
        m0_req = 1; m0_grnt = 1; m0_addr = 32'h1FC0_0000; m0_len = 4'd3; m0_size = 3'd2;
        axi.arready = 1'b1;
        tick();
        chk("t1_arvalid", axi.arvalid, 1);
        chk("t1_araddr", axi.araddr, 32'h1FC0_0000);
        chk("t1_arlen", axi.arlen, 3);
        chk("t1_arsize", axi.arsize, 2);
        chk("t1_arid", axi.arid, 0);
        tick();
        chk("t1_arvalid_drop", axi.arvalid, 0);
        chk("t1_rready", axi.rready, 1);
        beat(4'd0, 32'hD000_0000, 2'b00, 1'b0);
        chk("t1_b0", {m0_rvalid, m0_rlast, m0_done, m0_rdata}, {3'b100, 32'hD000_0000});
        beat(4'd0, 32'hD000_0001, 2'b00, 1'b0);
        chk("t1_b1", {m0_rvalid, m0_rlast, m0_done, m0_rdata}, {3'b100, 32'hD000_0001});
        beat(4'd0, 32'hD000_0002, 2'b00, 1'b0);
        chk("t1_b2", {m0_rvalid, m0_rlast, m0_done, m0_rdata}, {3'b100, 32'hD000_0002});
        chk("t1_others", {m1_rvalid, m2_rvalid, m1_done, m2_done}, 0);
        beat(4'd0, 32'hD000_0003, 2'b00, 1'b1);
        chk("t1_b3", {m0_rvalid, m0_rlast, m0_done, m0_err, m0_rdata},
            {4'b1110, 32'hD000_0003});
        chk("t1_rready_done", axi.rready, 0);
        m0_req = 0; m0_grnt = 0;
        tick();
        chk("t1_idle", {m0_rvalid, m0_rlast, m0_done, axi.arvalid}, 0);
        chk("t1_rdata_hold", m0_rdata, 32'hD000_0003);

        // m1 single beat, arready held low 5 cycles
        m1_req = 1; m1_grnt = 1; m1_addr = 32'h8000_0040; m1_len = 4'd0; m1_size = 3'd2;
        axi.arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_arvalid_wait", {axi.arvalid, axi.araddr, axi.arid},
                {1'b1, 32'h8000_0040, 4'd1});
        end
        axi.arready = 1'b1;
        tick();
        chk("t2_data", {axi.arvalid, axi.rready}, 2'b01);
        beat(4'd1, 32'hCAFE_0001, 2'b00, 1'b1);
        chk("t2_beat", {m1_rvalid, m1_rlast, m1_done, m1_err, m1_rdata},
            {4'b1110, 32'hCAFE_0001});
        chk("t2_m0_quiet", {m0_rvalid, m0_done}, 0);
        m1_req = 0; m1_grnt = 0;
        tick();

        // m2 two beats, second SLVERR
        m2_req = 1; m2_grnt = 1; m2_addr = 32'h0000_2000; m2_len = 4'd1;
        tick();
        chk("t3_arid", {axi.arvalid, axi.arid}, {1'b1, 4'd2});
        tick();
        beat(4'd2, 32'h2222_0000, 2'b00, 1'b0);
        chk("t3_b0", {m2_rvalid, m2_done, m2_err}, 3'b100);
        beat(4'd2, 32'h2222_0001, 2'b10, 1'b1);
        chk("t3_b1", {m2_rvalid, m2_rlast, m2_done, m2_err, m2_rdata},
            {4'b1111, 32'h2222_0001});
        m2_req = 0; m2_grnt = 0;
        tick();

        // grant switches to m1 mid-burst of m0
        m0_req = 1; m0_grnt = 1; m0_addr = 32'h0000_1000; m0_len = 4'd1;
        m1_addr = 32'h0000_3000; m1_len = 4'd0;
        tick();
        tick();
        m0_grnt = 0; m1_req = 1; m1_grnt = 1;
        tick();
        chk("t4_hold", {axi.rready, axi.araddr, axi.arid}, {1'b1, 32'h0000_1000, 4'd0});
        beat(4'd0, 32'h4444_0000, 2'b00, 1'b0);
        chk("t4_b0", {m0_rvalid, m1_rvalid}, 2'b10);
        beat(4'd0, 32'h4444_0001, 2'b00, 1'b1);
        chk("t4_m0_done", {m0_done, m1_done, m0_rdata}, {2'b10, 32'h4444_0001});
        m0_req = 0;
        tick();
        chk("t4_gap", axi.arvalid, 0);
        tick();
        chk("t4_m1_start", {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'd1, 32'h0000_3000});
        tick();
        beat(4'd1, 32'h5555_0000, 2'b00, 1'b1);
        chk("t4_m1_done", {m1_rvalid, m1_done}, 2'b11);
        m1_req = 0; m1_grnt = 0;
        tick();

        // foreign-ID beat is dropped, even with rlast
        m0_req = 1; m0_grnt = 1; m0_addr = 32'h0000_4000; m0_len = 4'd0;
        tick();
        tick();
        beat(4'd2, 32'hBAD0_BAD0, 2'b00, 1'b1);
        chk("t5_drop", {m0_rvalid, m2_rvalid, m0_done, axi.rready}, 4'b0001);
        beat(4'd0, 32'h6666_0000, 2'b00, 1'b1);
        chk("t5_route", {m0_rvalid, m0_done, m0_rdata}, {2'b11, 32'h6666_0000});
        m0_req = 0; m0_grnt = 0;
        tick();

        // reset mid-burst
        m0_req = 1; m0_grnt = 1; m0_addr = 32'h0000_5000; m0_len = 4'd3;
        tick();
        tick();
        beat(4'd0, 32'h7777_0000, 2'b00, 1'b0);
        beat(4'd0, 32'h7777_0001, 2'b00, 1'b0);
        m0_req = 0; m0_grnt = 0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst", {axi.arvalid, axi.rready, m0_rvalid, m0_rlast, m0_done}, 0);
        chk("t6_rst_rdata", m0_rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_idle", {axi.arvalid, axi.rready}, 0);
        m0_req = 1; m0_grnt = 1; m0_addr = 32'h0000_6000;
        tick();
        chk("t6_restart", {axi.arvalid, axi.araddr}, {1'b1, 32'h0000_6000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_load_port.md
Name: axi_load_port

Overview:
- Bus-side end of the AXI load bus.
- Consumes the one-hot grant produced by the load-bus arbiter (master 0 = data cache, master 1 = instruction cache, master 2 = uncached/auxiliary).
- Issues the granted master's read burst on the AXI AR channel, accepts R beats and routes them back to the owning master.
- Holds ownership until the burst completes, then signals done so the master drops its request and the arbiter can move on.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, AXI ID width; arid = owner index zero-extended.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req, m2_req  in  1 each  master read request, held until done.
- m0_grnt, m1_grnt, m2_grnt  in  1 each  grant from arbiter, expected one-hot.
- m0_addr, m1_addr, m2_addr  in  ADDR_W each  burst start address.
- m0_len, m1_len, m2_len  in  4 each  AXI arlen (beats-1).
- m0_size, m1_size, m2_size  in  3 each  AXI arsize.
- m0_rdata, m1_rdata, m2_rdata  out  DATA_W each  returned beat.
- m0_rvalid, m1_rvalid, m2_rvalid  out  1 each  beat valid pulse.
- m0_rlast, m1_rlast, m2_rlast  out  1 each  final beat.
- m0_done, m1_done, m2_done  out  1 each  burst complete pulse.
- m0_err, m1_err, m2_err  out  1 each  any beat had rresp != OKAY (valid with done).
- arid  out  ID_W  read ID.
- araddr  out  ADDR_W  read address.
- arlen  out  4  burst length.
- arsize  out  3  beat size.
- arburst  out  2  fixed INCR (2'b01).
- arvalid  out  1  address valid.
- arready  in  1  address ready.
- rid  in  ID_W  response ID.
- rdata  in  DATA_W  response data.
- rresp  in  2  response code.
- rlast  in  1  last beat.
- rvalid  in  1  beat valid.
- rready  out  1  beat ready.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Clears state to IDLE and every output to 0; arburst is a constant 2'b01. Reset mid-burst drops arvalid/rready immediately; the system-wide reset covers the AXI slave.
- State IDLE:
  - Acts only on a master whose grnt and req are both 1.
  - If several grants are 1, priority is m0 > m1 > m2.
  - On that master, latch owner, addr, len, size; clear the error flag; go to ADDR.
  - Request seen at cycle N gives arvalid=1 at N+1.
- State ADDR:
  - arvalid=1; araddr/arlen/arsize/arid are held stable from the latched values.
  - On arready=1, go to DATA; arvalid drops the next cycle.
  - Grant and request changes are ignored.
- State DATA:
  - rready=1.
  - Accepted beat (rvalid & rready & rid==arid) at cycle t: owner's rdata/rvalid registered and visible at t+1; rlast is forwarded alongside. Non-owners' rvalid stay 0.
  - Beat with rid != arid: consumed and dropped, no master pulse.
  - rresp != 2'b00 on an accepted beat sets the sticky error flag.
  - Accepted beat with rlast=1: go to DONE.
  - If rlast arrives before len+1 beats, the burst ends at rlast. Beats beyond len are still routed; no beat counter is enforced.
- State DONE (1 cycle):
  - Owner's done=1 and err = sticky flag, in the same cycle as the last rvalid/rlast.
  - Next state is IDLE.
  - The master must deassert req on the edge ending DONE; req still high in the following IDLE cycle is treated as a new request.
- Pulse widths: mN_rvalid, mN_rlast, mN_done, mN_err are single-cycle; rdata holds its last value otherwise.
- Throughput: back-to-back bursts cost 2 idle cycles (DONE, IDLE) between the last beat and the next arvalid.

Decomposition:
- Shared package constants: owner encoding (OWN_M0=2'b00, OWN_M1=2'b01, OWN_M2=2'b10), burst type BURST_INCR=2'b01, resp codes RESP_OKAY/EXOKAY/SLVERR/DECERR, state encoding.
- No sub-module. Single FSM plus a latch/route datapath, roughly 200 RTL lines.

Test Plan:
- m0_req=m0_grnt=1, addr=0x1FC0_0000, len=3, arready immediate, 4 beats D0..D3 rid=0 -> arvalid one cycle after req; m0_rvalid ×4 with D0..D3; m0_rlast and m0_done with D3; m0_err=0; m1/m2 outputs stay 0.
- m1 burst len=0; arready held low 5 cycles -> arvalid high 5 cycles, araddr stable; single beat routed to m1 with rlast+done; arid=1.
- m2 burst len=1; second beat rresp=SLVERR -> m2_err=1 coincident with m2_done.
- During an m0 burst, arbiter switches grant to m1 and m1_req=1 -> no change to araddr/arid; m0 completes; m1 burst starts 2 cycles after m0_done.
- Beat with rid=2 while owner=0 -> rready=1, beat dropped, no m0_rvalid; next rid=0 beat routed normally.
- rst_n low in DATA after 2 of 4 beats -> all outputs 0 immediately; after release, IDLE; a new m0 request produces arvalid one cycle after it is seen.
